// File: rtl/bram_rd_arbiter.sv
// Round-robin share of one 1-cycle-latency BRAM read port between two requesters, per-port 2-entry response FIFOs.
// Latency: accept in cycle T, response data_valid in T+2; up to one read issued per cycle.
// Backpressure: a port is granted only while its FIFO has room for every outstanding read; the other port is unaffected.
module bram_rd_arbiter #(
    parameter int W_DATA = 8,
    parameter int W_ADDR = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_addr_valid,
    output logic              req0_addr_ready,
    input  logic [W_ADDR-1:0] req0_addr_data,
    output logic              req0_data_valid,
    input  logic              req0_data_ready,
    output logic [W_DATA-1:0] req0_data,
    input  logic              req1_addr_valid,
    output logic              req1_addr_ready,
    input  logic [W_ADDR-1:0] req1_addr_data,
    output logic              req1_data_valid,
    input  logic              req1_data_ready,
    output logic [W_DATA-1:0] req1_data,
    output logic              ena,
    output logic [W_ADDR-1:0] addra,
    input  logic [W_DATA-1:0] doa
);

    logic [1:0]        addr_valid;
    logic [1:0]        data_ready;
    logic [1:0]        pop;
    logic [1:0]        push;
    logic [1:0]        eligible;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic [1:0]        count [2];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [W_DATA-1:0] mem [2][2];
    logic              flight_v;
    logic              flight_id;
    logic              rr;

    assign addr_valid = {req1_addr_valid, req0_addr_valid};
    assign data_ready = {req1_data_ready, req0_data_ready};

    always_comb begin
        pop      = '0;
        push     = '0;
        eligible = '0;
        req      = '0;
        for (int i = 0; i < 2; i++) begin
            pop[i]  = (count[i] != 2'd0) & data_ready[i];
            push[i] = flight_v & (flight_id == 1'(i));
            // Slot freed by a same-cycle pop counts, so one port alone can stream at full rate.
            eligible[i] = ({1'b0, count[i]} + {2'b00, push[i]}) < (3'd2 + {2'b00, pop[i]});
            req[i]      = addr_valid[i] & eligible[i] & rst;
        end
        grant[0] = req[0] & (~req[1] | ~rr);
        grant[1] = req[1] & (~req[0] | rr);
    end

    assign req0_addr_ready = grant[0];
    assign req1_addr_ready = grant[1];
    assign ena             = |grant;
    assign addra           = grant[0] ? req0_addr_data :
                             grant[1] ? req1_addr_data : '0;

    assign req0_data_valid = (count[0] != 2'd0);
    assign req1_data_valid = (count[1] != 2'd0);
    assign req0_data       = mem[0][rd_ptr[0]];
    assign req1_data       = mem[1][rd_ptr[1]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flight_v  <= 1'b0;
            flight_id <= 1'b0;
            rr        <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < 2; i++) begin
                count[i]  <= '0;
                mem[i][0] <= '0;
                mem[i][1] <= '0;
            end
        end else begin
            flight_v  <= |grant;
            flight_id <= grant[1];
            if (|grant) begin
                rr <= grant[0];
            end
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= doa;
                    wr_ptr[i]         <= ~wr_ptr[i];
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
                count[i] <= count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
        end
    end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed and random stimulus for bram_rd_arbiter, checked against a queue-based reference model.
module tb_bram_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  av;
    logic [1:0]  rdy;
    logic [11:0] ad [2];
    logic [7:0]  doa;
    wire         ar0, ar1, dv0, dv1, ena;
    wire  [7:0]  dd0, dd1;
    wire  [11:0] addra;

    always #5 clk = ~clk;

    bram_rd_arbiter #(.W_DATA(8), .W_ADDR(12)) dut (
        .clk(clk), .rst(rst),
        .req0_addr_valid(av[0]), .req0_addr_ready(ar0), .req0_addr_data(ad[0]),
        .req0_data_valid(dv0), .req0_data_ready(rdy[0]), .req0_data(dd0),
        .req1_addr_valid(av[1]), .req1_addr_ready(ar1), .req1_addr_data(ad[1]),
        .req1_data_valid(dv1), .req1_data_ready(rdy[1]), .req1_data(dd1),
        .ena(ena), .addra(addra), .doa(doa)
    );

    function automatic logic [7:0] memf(input logic [11:0] a);
        return a[7:0] ^ 8'h5A ^ {a[11:8], a[11:8]};
    endfunction

    // BRAM: registered read; garbage on doa whenever no read was issued.
    always @(posedge clk) doa <= ena ? memf(addra) : 8'($urandom);

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fq0 [$];
    logic [7:0]  fq1 [$];
    bit          pv;
    int          pid;
    logic [7:0]  pw;
    int          prio;
    int          acc [2];
    int          rx [2];
    bit          acc_now [2];
    int          left [2];
    logic [11:0] nxt [2];
    bit          rnd;
    bit          first_arm;
    int          first_obs;
    int          exp_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0;
            rx[i]  = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (!av[i] || acc_now[i]) begin
                if (rnd) begin
                    av[i] = 1'($urandom_range(0, 1));
                    ad[i] = 12'($urandom);
                end else if (left[i] > 0) begin
                    av[i] = 1'b1;
                    ad[i] = nxt[i];
                    nxt[i]++;
                    left[i]--;
                end else begin
                    av[i] = 1'b0;
                end
            end
        end
        if (rnd) rdy = 2'($urandom);
    endtask

    task automatic step();
        int         sz [2];
        bit         mv [2];
        bit         pp [2];
        bit         rq [2];
        int         outst;
        int         g;
        @(negedge clk);
        sz[0] = fq0.size();
        sz[1] = fq1.size();
        for (int i = 0; i < 2; i++) begin
            mv[i] = sz[i] > 0;
            pp[i] = mv[i] && rdy[i];
            outst = sz[i] + ((pv && pid == i) ? 1 : 0) - (pp[i] ? 1 : 0);
            rq[i] = av[i] && (outst < 2);
        end
        g = -1;
        if (rq[0] && rq[1]) g = prio;
        else if (rq[0]) g = 0;
        else if (rq[1]) g = 1;
        chk("addr_ready0", 32'(ar0), 32'(g == 0));
        chk("addr_ready1", 32'(ar1), 32'(g == 1));
        chk("ena", 32'(ena), 32'(g >= 0));
        chk("addra", 32'(addra), (g >= 0) ? 32'(ad[g]) : 32'd0);
        chk("data_valid0", 32'(dv0), 32'(mv[0]));
        chk("data_valid1", 32'(dv1), 32'(mv[1]));
        if (mv[0]) chk("data0", 32'(dd0), 32'(fq0[0]));
        if (mv[1]) chk("data1", 32'(dd1), 32'(fq1[0]));
        if (first_arm && (ar0 || ar1)) begin
            first_obs = int'(ar1);
            first_arm = 1'b0;
        end
        if (dv0 && rdy[0]) rx[0]++;
        if (dv1 && rdy[1]) rx[1]++;
        @(posedge clk);
        if (pp[0]) void'(fq0.pop_front());
        if (pp[1]) void'(fq1.pop_front());
        if (pv) begin
            if (pid == 0) fq0.push_back(pw);
            else fq1.push_back(pw);
            chk("fifo_no_overflow", 32'((fq0.size() <= 2) && (fq1.size() <= 2)), 32'd1);
        end
        pv = (g >= 0);
        if (pv) begin
            pid = g;
            pw  = memf(ad[g]);
            prio = 1 - g;
            acc[g]++;
        end
        acc_now[0] = (g == 0);
        acc_now[1] = (g == 1);
        #1;
        drive();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ena"}, 32'(ena), 32'd0);
        chk({tag, "_addra"}, 32'(addra), 32'd0);
        chk({tag, "_addr_ready"}, {30'd0, ar1, ar0}, 32'd0);
        chk({tag, "_data_valid"}, {30'd0, dv1, dv0}, 32'd0);
        chk({tag, "_data0"}, 32'(dd0), 32'd0);
        chk({tag, "_data1"}, 32'(dd1), 32'd0);
    endtask

    // Called just after a rising edge; asserts reset mid-cycle, releases it just after a later edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1 reset_checks("rst_immediate");
        fq0.delete();
        fq1.delete();
        pv = 1'b0;
        prio = 0;
        acc_now[0] = 1'b0;
        acc_now[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            reset_checks("rst_held");
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        av = '0;
        rdy = '0;
        ad[0] = '0;
        ad[1] = '0;
        pv = 1'b0;
        prio = 0;
        rnd = 1'b0;
        first_arm = 1'b0;
        first_obs = -1;
        for (int i = 0; i < 2; i++) begin
            acc_now[i] = 1'b0;
            left[i] = 0;
            nxt[i] = '0;
        end
        repeat (2) @(negedge clk);
        reset_checks("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Single port streaming 0x000..0x00F
        rdy = 2'b11;
        nxt[0] = 12'h000; left[0] = 16;
        clear_cnt();
        drive();
        repeat (16) step();
        chk("single_accepts", 32'(acc[0]), 32'd16);
        chk("single_port1_idle", 32'(acc[1]), 32'd0);
        repeat (6) step();
        chk("single_words", 32'(rx[0]), 32'd16);

        // Contention from reset: strict alternation starting at port 0
        do_reset();
        nxt[0] = 12'h010; left[0] = 10;
        nxt[1] = 12'h100; left[1] = 10;
        clear_cnt();
        first_arm = 1'b1;
        drive();
        repeat (20) step();
        chk("contend_first_grant", 32'(first_obs), 32'd0);
        chk("contend_acc0", 32'(acc[0]), 32'd10);
        chk("contend_acc1", 32'(acc[1]), 32'd10);
        repeat (4) step();
        chk("contend_rx0", 32'(rx[0]), 32'd10);
        chk("contend_rx1", 32'(rx[1]), 32'd10);

        // Backpressure on port 0, port 1 keeps streaming
        rdy = 2'b10;
        nxt[0] = 12'h200; left[0] = 20;
        nxt[1] = 12'h300; left[1] = 20;
        clear_cnt();
        drive();
        repeat (12) step();
        chk("bp_acc0", 32'(acc[0]), 32'd2);
        chk("bp_acc1_rate", 32'(acc[1] >= 9), 32'd1);
        chk("bp_full_valid", 32'(dv0), 32'd1);
        chk("bp_blocked", 32'(ar0), 32'd0);
        rdy = 2'b11;
        clear_cnt();
        repeat (2) step();
        chk("bp_drain", 32'(rx[0]), 32'd2);
        repeat (30) step();
        chk("bp_resume_acc0", 32'(acc[0]), 32'd18);
        repeat (4) step();

        // Reset while a read is in flight and both FIFOs hold data
        do_reset();
        rdy = 2'b00;
        nxt[0] = 12'h400; left[0] = 8;
        nxt[1] = 12'h500; left[1] = 8;
        clear_cnt();
        drive();
        repeat (3) step();
        chk("pre_rst_valid0", 32'(dv0), 32'd1);
        chk("pre_rst_valid1", 32'(dv1), 32'd1);
        chk("pre_rst_in_flight", 32'(pv), 32'd1);
        do_reset();
        rdy = 2'b11;
        clear_cnt();
        first_arm = 1'b1;
        repeat (24) step();
        chk("post_rst_first_grant", 32'(first_obs), 32'd0);
        chk("post_rst_rx0", 32'(rx[0]), 32'd6);
        chk("post_rst_rx1", 32'(rx[1]), 32'd7);

        // Idle, then contention must honour the held priority
        clear_cnt();
        repeat (10) step();
        chk("idle_no_grants", 32'(acc[0] + acc[1]), 32'd0);
        exp_first = prio;
        nxt[0] = 12'h600; left[0] = 2;
        nxt[1] = 12'h700; left[1] = 2;
        first_arm = 1'b1;
        drive();
        repeat (8) step();
        chk("idle_rr_held", 32'(first_obs), 32'(exp_first));

        // Random traffic and backpressure
        rnd = 1'b1;
        drive();
        repeat (400) step();
        rnd = 1'b0;
        left[0] = 0;
        left[1] = 0;
        rdy = 2'b11;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
